// File: rtl/pipe_chain.sv
// -----------------------------------------------------------------------------
// pipe_chain
//   In-order pipeline register chain with per-stage valid tracking. Items enter
//   at stage 0 and leave from stage STAGES-1. Empty stages absorb upstream data
//   while a downstream stage is held, so bubbles collapse.
//
// Parameters
//   DW      payload width per stage
//   STAGES  number of stages (2..16)
//   CW      occupancy counter width (derived)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   in_valid     producer offers in_data
//   in_data      payload entering stage 0
//   in_ready     stage 0 accepts this cycle
//   out_valid    last stage holds a live item
//   out_data     last-stage payload
//   out_ready    consumer takes the last-stage item
//   freeze       global stall; no state changes
//   hold         bit i: stage i must not pass its item forward
//   flush        bit i: kill the item currently in stage i
//   stage_valid  valid bit per stage
//   stage_data   stage i payload at bits [i*DW +: DW]
//   occupancy    number of valid stages (registered)
// -----------------------------------------------------------------------------
module pipe_chain #(
    parameter  int DW     = 32,
    parameter  int STAGES = 5,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DW-1:0]          in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DW-1:0]          out_data,
    input  logic                   out_ready,
    input  logic                   freeze,
    input  logic [STAGES-1:0]      hold,
    input  logic [STAGES-1:0]      flush,
    output logic [STAGES-1:0]      stage_valid,
    output logic [STAGES*DW-1:0]   stage_data,
    output logic [CW-1:0]          occupancy
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [DW-1:0]     data_q [STAGES];
    logic [DW-1:0]     data_d [STAGES];
    logic [CW-1:0]     occ_q, occ_d;

    logic [STAGES-1:0] flush_eff;
    logic [STAGES-1:0] live;
    logic [STAGES-1:0] kill;
    logic [STAGES-1:0] adv;
    logic [STAGES:0]   rdy;
    logic              in_fire;

    // Ready chain, evaluated from the output end back towards the input.
    // Flush is ignored while frozen; the requester keeps it asserted.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        flush_eff   = flush & {STAGES{~freeze}};
        live        = valid_q & ~flush_eff;
        kill        = valid_q & flush_eff;
        adv         = '0;
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i] = live[i] & ~hold[i] & rdy[i+1];
            // An empty or killed stage is ready even when held.
            rdy[i] = ~live[i] | adv[i];
        end
    end

    assign in_ready  = rdy[0] & ~freeze;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = live[STAGES-1];
    assign out_data  = data_q[STAGES-1];

    // Next state: a load from upstream wins over invalidation, so a flushed
    // stage can still take a new item in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = '0;
        if (!freeze) begin
            if (in_fire) begin
                valid_d[0] = 1'b1;
                data_d[0]  = in_data;
            end else if (adv[0] || kill[0]) begin
                valid_d[0] = 1'b0;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (adv[i-1]) begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = data_q[i-1];
                end else if (adv[i] || kill[i]) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
        // Occupancy tracks the popcount of the valid bits being registered.
        for (int i = 0; i < STAGES; i++) begin
            occ_d = occ_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            occ_q   <= '0;
            // NOTE: the payload array is reset too, because downstream
            // forwarding logic observes stage_data directly and expects zeros
            // after reset; this costs a reset net on every payload flop.
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its neighbours, which is what makes the
            // chain shift by exactly one stage per edge.
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*DW +: DW] = data_q[i];
        end
    end

    assign stage_valid = valid_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_chain.sv
// -----------------------------------------------------------------------------
// tb_pipe_chain
//   Directed bench for pipe_chain (STAGES=5, DW=32): a table of streaming
//   vectors followed by hand-written backpressure, flush, bubble-collapse,
//   freeze and asynchronous-reset sequences.
// -----------------------------------------------------------------------------
module tb_pipe_chain;

    localparam int DW     = 32;
    localparam int STAGES = 5;
    localparam int CW     = $clog2(STAGES + 1);

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic [DW-1:0]        in_data;
    logic                 in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_ready;
    logic                 freeze;
    logic [STAGES-1:0]    hold;
    logic [STAGES-1:0]    flush;
    logic [STAGES-1:0]    stage_valid;
    logic [STAGES*DW-1:0] stage_data;
    logic [CW-1:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [8];

    pipe_chain #(.DW(DW), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .freeze     (freeze),
        .hold       (hold),
        .flush      (flush),
        .stage_valid(stage_valid),
        .stage_data (stage_data),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [4:0]  exp_sv;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic ordy,
                                input logic eir, input logic eov, input logic [31:0] eod,
                                input logic [4:0] esv, input logic [2:0] eocc);
        vec_t v;
        v.in_valid      = iv;
        v.in_data       = id;
        v.out_ready     = ordy;
        v.exp_in_ready  = eir;
        v.exp_out_valid = eov;
        v.exp_out_data  = eod;
        v.exp_sv        = esv;
        v.exp_occ       = eocc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] sd(input int j);
        return stage_data[j*DW +: DW];
    endfunction

    // Let the chain run with out_ready high and compare every item that
    // leaves against exp_q, in order.
    task automatic drain(input string tag, input int n_exp);
        int got;
        got = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        hold      = '0;
        flush     = '0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) begin
                if (got < n_exp) check({tag, "_data"}, 64'(out_data), 64'(exp_q[got]));
                got++;
            end
            tick();
        end
        check({tag, "_count"}, 64'(got), 64'(n_exp));
        check({tag, "_empty"}, 64'(occupancy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int got;

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        freeze    = 1'b0;
        hold      = '0;
        flush     = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_sv",       64'(stage_valid), 64'(0));
        check("rst_occ",      64'(occupancy),   64'(0));
        check("rst_out_valid",64'(out_valid),   64'(0));
        check("rst_data",     64'(stage_data),  64'(0));
        check("empty_in_ready", 64'(in_ready),  64'(1));
        freeze = 1'b1;
        #1;
        check("empty_frz_in_ready", 64'(in_ready), 64'(0));
        freeze = 1'b0;
        rst    = 1'b1;
        tick();

        // ---------------- streaming table ----------------
        vecs[0]  = mk(1, 32'h1, 1, 1, 0, 32'h0, 5'b00000, 3'd0);
        vecs[1]  = mk(1, 32'h2, 1, 1, 0, 32'h0, 5'b00001, 3'd1);
        vecs[2]  = mk(1, 32'h3, 1, 1, 0, 32'h0, 5'b00011, 3'd2);
        vecs[3]  = mk(1, 32'h4, 1, 1, 0, 32'h0, 5'b00111, 3'd3);
        vecs[4]  = mk(1, 32'h5, 1, 1, 0, 32'h0, 5'b01111, 3'd4);
        vecs[5]  = mk(1, 32'h6, 1, 1, 1, 32'h1, 5'b11111, 3'd5);
        vecs[6]  = mk(1, 32'h7, 1, 1, 1, 32'h2, 5'b11111, 3'd5);
        vecs[7]  = mk(1, 32'h8, 1, 1, 1, 32'h3, 5'b11111, 3'd5);
        vecs[8]  = mk(0, 32'h0, 1, 1, 1, 32'h4, 5'b11111, 3'd5);
        vecs[9]  = mk(0, 32'h0, 1, 1, 1, 32'h5, 5'b11110, 3'd4);
        vecs[10] = mk(0, 32'h0, 1, 1, 1, 32'h6, 5'b11100, 3'd3);
        vecs[11] = mk(0, 32'h0, 1, 1, 1, 32'h7, 5'b11000, 3'd2);
        vecs[12] = mk(0, 32'h0, 1, 1, 1, 32'h8, 5'b10000, 3'd1);
        vecs[13] = mk(0, 32'h0, 1, 1, 0, 32'h0, 5'b00000, 3'd0);

        for (int r = 0; r < 14; r++) begin
            in_valid  = vecs[r].in_valid;
            in_data   = vecs[r].in_data;
            out_ready = vecs[r].out_ready;
            #1;
            check($sformatf("stream%0d_in_ready", r),  64'(in_ready),    64'(vecs[r].exp_in_ready));
            check($sformatf("stream%0d_out_valid", r), 64'(out_valid),   64'(vecs[r].exp_out_valid));
            check($sformatf("stream%0d_sv", r),        64'(stage_valid), 64'(vecs[r].exp_sv));
            check($sformatf("stream%0d_occ", r),       64'(occupancy),   64'(vecs[r].exp_occ));
            if (vecs[r].exp_out_valid)
                check($sformatf("stream%0d_out_data", r), 64'(out_data), 64'(vecs[r].exp_out_data));
            tick();
        end
        in_valid = 1'b0;

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc       = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = 32'hA0 + 32'(acc);
            #1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("bp_accepts",  64'(acc),       64'(5));
        check("bp_in_ready", 64'(in_ready),  64'(0));
        check("bp_occ",      64'(occupancy), 64'(5));
        for (int k = 0; k < 5; k++) exp_q[k] = 32'hA0 + 32'(k);
        drain("bp_drain", 5);

        // ---------------- flush ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h14 - 32'(k);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("fl_pre_sv", 64'(stage_valid), 64'(5'b11111));
        for (int j = 0; j < 5; j++)
            check($sformatf("fl_pre_data%0d", j), 64'(sd(j)), 64'(32'h10 + 32'(j)));
        flush = 5'b00111;
        tick();
        flush = '0;
        #1;
        check("fl_sv",  64'(stage_valid), 64'(5'b11000));
        check("fl_occ", 64'(occupancy),   64'(2));
        exp_q[0] = 32'h14;
        exp_q[1] = 32'h13;
        drain("fl_drain", 2);

        // ---------------- bubble collapse ----------------
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'hAA;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        hold     = 5'b00100;
        in_valid = 1'b1;
        in_data  = 32'hBB;
        #1;
        check("bub_b_ready", 64'(in_ready), 64'(1));
        tick();
        in_data = 32'hCC;
        #1;
        check("bub_c_ready", 64'(in_ready), 64'(1));
        tick();
        in_data = 32'hDD;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("bub%0d_in_ready", c), 64'(in_ready),    64'(0));
            check($sformatf("bub%0d_sv", c),       64'(stage_valid), 64'(5'b00111));
            check($sformatf("bub%0d_s2", c),       64'(sd(2)),       64'(32'hAA));
            check($sformatf("bub%0d_s1", c),       64'(sd(1)),       64'(32'hBB));
            check($sformatf("bub%0d_s0", c),       64'(sd(0)),       64'(32'hCC));
            tick();
        end
        exp_q[0] = 32'hAA;
        exp_q[1] = 32'hBB;
        exp_q[2] = 32'hCC;
        drain("bub_drain", 3);

        // ---------------- freeze ----------------
        out_ready = 1'b1;
        n   = 1;
        got = 0;
        for (int c = 0; c < 40; c++) begin
            freeze   = (c >= 6 && c < 9);
            in_valid = (n <= 8);
            in_data  = 32'h2F + 32'(n);
            #1;
            if (freeze) begin
                check($sformatf("frz%0d_in_ready", c),  64'(in_ready),  64'(0));
                check($sformatf("frz%0d_occ", c),       64'(occupancy), 64'(5));
                check($sformatf("frz%0d_out_valid", c), 64'(out_valid), 64'(1));
                check($sformatf("frz%0d_s4", c),        64'(sd(4)),     64'(32'h31));
                check($sformatf("frz%0d_s0", c),        64'(sd(0)),     64'(32'h35));
            end
            if (out_valid && out_ready && !freeze) begin
                if (got < 8) check($sformatf("frz_out%0d", got), 64'(out_data), 64'(32'h30 + 32'(got)));
                got++;
            end
            if (in_valid && in_ready) n++;
            tick();
        end
        freeze   = 1'b0;
        in_valid = 1'b0;
        check("frz_count", 64'(got), 64'(8));

        // ---------------- asynchronous reset ----------------
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = 32'h61 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        #1;
        check("ar_pre_sv", 64'(stage_valid), 64'(5'b00111));
        #2;
        rst = 1'b0;
        #1;
        check("ar_sv",        64'(stage_valid), 64'(0));
        check("ar_out_valid", 64'(out_valid),   64'(0));
        check("ar_occ",       64'(occupancy),   64'(0));
        check("ar_data",      64'(stage_data),  64'(0));
        tick();
        tick();
        check("ar_held_sv", 64'(stage_valid), 64'(0));
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h55;
        #1;
        check("ar_post_in_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        for (int r = 1; r <= 5; r++) begin
            #1;
            if (r < 5) begin
                check($sformatf("ar_lat%0d_out_valid", r), 64'(out_valid), 64'(0));
            end else begin
                check("ar_lat5_out_valid", 64'(out_valid), 64'(1));
                check("ar_lat5_out_data",  64'(out_data),  64'(32'h55));
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised in-order pipeline register chain with per-stage valid tracking. It replaces the fixed five-stage enable/clear register bank in the CPU datapath. It adds:
- `STAGES`-deep, `DW`-wide stages
- valid/ready handshake at both ends
- per-stage hold and flush
- a global freeze for cache stalls
- bubble collapse, so empty stages absorb upstream data while a downstream stage is held

It sits between decode-side producers and execute/memory consumers. It exposes every stage's contents for forwarding logic.

## Interface
- `DW`, 32: payload width per stage.
- `STAGES`, 5: number of stages; legal range 2..16.
- `CW`, `$clog2(STAGES+1)`: occupancy counter width (derived; do not override).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `in_valid`  in  1  producer offers `in_data`.
- `in_data`  in  DW  payload entering stage 0.
- `in_ready`  out  1  stage 0 accepts this cycle.
- `out_valid`  out  1  last stage holds a valid item.
- `out_data`  out  DW  last-stage payload.
- `out_ready`  in  1  consumer takes the last-stage item.
- `freeze`  in  1  global stall: no state changes (I/D cache miss).
- `hold`  in  STAGES  bit i: stage i must not pass its item forward.
- `flush`  in  STAGES  bit i: kill the item currently in stage i.
- `stage_valid`  out  STAGES  valid bit per stage.
- `stage_data`  out  STAGES*DW  stage i payload at bits [i*DW +: DW].
- `occupancy`  out  CW  number of valid stages.

## Operation
- Stage 0 is nearest the input; stage STAGES-1 drives `out_*`.
- Let `v_i` = `stage_valid[i]` and `f_i` = `flush[i]`.
- **Kill:** `k_i` = `v_i & f_i`. A killed item never advances and is discarded.
- **Live:** `l_i` = `v_i & ~f_i`.
- **Downstream ready:** `r_{STAGES}` = `out_ready`.
- **Advance:** `adv_i` = `l_i & ~hold[i] & r_{i+1}`.
- **Stage ready:** `r_i` = `~l_i | adv_i`. An empty or flushed stage is ready regardless of `hold[i]`.
- **Handshake outputs:**
  - `in_ready` = `r_0 & ~freeze`.
  - `out_valid` = `l_{STAGES-1}`.
- **Fire conditions:**
  - An input fires on `in_valid & in_ready`.
  - An output fires on `out_valid & out_ready & ~freeze`.
- **Next state for stage i (freeze low), in priority order:**
  1. Load from stage i-1 (or input for i=0) if that source fires into i: `v_i`<=1, data <= source data.
  2. Else if `adv_i` or `k_i`: `v_i`<=0, data unchanged.
  3. Else: hold.
- **Flush and entry:** `flush[i]` does not block a new item entering stage i in the same cycle.
- **Freeze:**
  - All state holds and all fires are suppressed.
  - `flush` and `hold` are ignored; the requester must keep `flush` asserted until freeze deasserts.
  - `out_valid` and `stage_*` remain visible.
- **Data on invalidate:** payload registers are not cleared on flush or advance; only valid bits change. Consumers qualify data with `stage_valid`.
- **Occupancy:** `occupancy` = popcount of registered `stage_valid`. It is registered state, not a function of the current cycle's handshakes.
- **Reset:** the `rst` falling edge immediately sets `stage_valid`=0, all payloads=0, `occupancy`=0, `out_valid`=0. Reset mid-transfer discards all in-flight items with no partial output. `in_ready` may be 1 during reset only if `freeze`=0; the producer must not rely on fires during reset, and no state updates until `rst` deasserts.

## Timing
- Latency: an item accepted at edge t appears on `out_valid` at edge t+STAGES-1 when nothing is held. That is STAGES cycles from `in_valid` to the `out_valid` cycle.
- Throughput: one item per cycle when unobstructed.
- `in_ready` is combinational from `out_ready`, `hold`, `flush` and `freeze`, through a STAGES-deep ready chain. No combinational path runs from `in_valid` to `in_ready` or to `out_valid`.
- Order is strictly preserved; no item is ever duplicated.
- Full: all `v_i`=1, no advance → `in_ready`=0, `occupancy`=STAGES.
- Empty: `out_valid`=0; `in_ready`=~freeze.
- Simultaneous input fire and output fire with full chain and no hold: occupancy unchanged.

## Test plan
- **Streaming:** STAGES=5, DW=32. Stream 0x1..0x8 with `in_valid`=1, `out_ready`=1. Required: 0x1 on `out_data` 4 edges after its accept, then 0x2..0x8 on consecutive cycles; `occupancy` peaks at 5.
- **Backpressure:** `out_ready`=0, stream 0xA0.. Required: exactly 5 accepts, then `in_ready`=0 and `occupancy`=5. Raising `out_ready` drains 0xA0..0xA4 in order.
- **Bubble collapse:** A at stage 2, stages 0–1 empty, `hold[2]`=1 for 4 cycles, B and C offered. Required:
  - B and C accepted.
  - B stops at stage 1 and C at stage 0; `in_ready`=0 afterward.
  - A stays at stage 2.
  - On `hold` release, A, B, C exit in order.
- **Flush:** items 0x10..0x14 in stages 0..4, `out_ready`=0. Pulse `flush`=5'b00111 with `in_valid`=0. Required: `stage_valid`=5'b11000, `occupancy`=2, and only 0x13 and 0x14 ever emerge.
- **Freeze:** assert `freeze` for 3 cycles mid-stream with `out_ready`=1. Required:
  - `in_ready`=0.
  - No output fire; `stage_data` and `occupancy` frozen.
  - Streaming resumes on the cycle freeze drops, with no loss or duplication.
- **Async reset:** drop `rst` mid-cycle with 3 items in flight. Required: `stage_valid`=0, `out_valid`=0, `occupancy`=0 before the next clock edge. After release, a fresh item traverses in 5 cycles.
